// File: rtl/store_buffer_unit.sv
// store_buffer_unit
//   Store queue that sits between the load/store unit and memory. Each
//   accepted store is turned into lane-aligned write data plus byte enables
//   for a word-aligned address. A store that crosses a word boundary is
//   either split into two beats (SPLIT_MISALIGNED=1) or rejected with a
//   misalign_err pulse (SPLIT_MISALIGNED=0).
//
// Parameters
//   XLEN              data/address width (32 or 64)
//   DEPTH             queue entries (power of 2, >= 2)
//   SPLIT_MISALIGNED  1 = split word-crossing stores, 0 = reject them
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   st_valid/st_ready          store request handshake
//   st_addr/st_data/st_funct3  byte address, LSB-justified data, size code
//   mem_valid/mem_ready        queue head handshake toward memory
//   mem_addr/mem_wdata/mem_be  head entry (zeroed when the queue is empty)
//   misalign_err, illegal_err  one-cycle pulses for rejected stores
//   count                      occupied entries
module store_buffer_unit #(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 4,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [XLEN-1:0]          st_addr,
  input  logic [XLEN-1:0]          st_data,
  input  logic [2:0]               st_funct3,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_be,
  output logic                     misalign_err,
  output logic                     illegal_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [NB-1:0]   be_q   [DEPTH];
  logic [NB-1:0]   be_d   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_err_q, misalign_err_d;
  logic          illegal_err_q, illegal_err_d;

  logic [3:0]        size_b;
  logic [OW-1:0]     off;
  logic [4:0]        end_b;
  logic              is_illegal;
  logic              crosses;
  logic              accept;
  logic              deq;
  logic [1:0]        enq_n;
  logic [NB-1:0]     be_base;
  logic [XLEN-1:0]   data_base;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] data_wide;
  logic [XLEN-1:0]   base_addr;

  // Request decode: the store is laid into a two-word window so that the
  // low word is beat0 and the high word is beat1 of a crossing store.
  always_comb begin
    size_b     = 4'd1 << st_funct3[1:0];
    off        = st_addr[OW-1:0];
    end_b      = 5'(off) + 5'(size_b);
    is_illegal = st_funct3[2] || ((XLEN == 32) && (st_funct3[1:0] == 2'b11));
    crosses    = end_b > 5'(NB);
    be_base    = '0;
    data_base  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(size_b)) begin
        be_base[i]          = 1'b1;
        data_base[8*i +: 8] = st_data[8*i +: 8];
      end
    end
    be_wide   = {{NB{1'b0}}, be_base} << off;
    data_wide = {{XLEN{1'b0}}, data_base} << {off, 3'b000};
    base_addr = {st_addr[XLEN-1:OW], {OW{1'b0}}};
  end

  // Ready is conservative: two free slots regardless of request type.
  assign st_ready  = rst_n && (count_q <= CW'(DEPTH - 2));
  assign mem_valid = (count_q != '0);
  assign accept    = st_valid && st_ready;
  assign deq       = mem_valid && mem_ready;
  assign wr_ptr_nx = wr_ptr_q + PW'(1);

  always_comb begin
    enq_n = 2'd0;
    if (accept && !is_illegal) begin
      if (!crosses)                   enq_n = 2'd1;
      else if (SPLIT_MISALIGNED != 0) enq_n = 2'd2;
    end

    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (enq_n != 2'd0) begin
      addr_d[wr_ptr_q] = base_addr;
      data_d[wr_ptr_q] = data_wide[XLEN-1:0];
      be_d[wr_ptr_q]   = be_wide[NB-1:0];
    end
    if (enq_n == 2'd2) begin
      addr_d[wr_ptr_nx] = base_addr + XLEN'(NB);
      data_d[wr_ptr_nx] = data_wide[2*XLEN-1:XLEN];
      be_d[wr_ptr_nx]   = be_wide[2*NB-1:NB];
    end

    wr_ptr_d       = wr_ptr_q + PW'(enq_n);
    rd_ptr_d       = rd_ptr_q + PW'(deq);
    count_d        = count_q + CW'(enq_n) - CW'(deq);
    illegal_err_d  = accept && is_illegal;
    misalign_err_d = accept && !is_illegal && crosses && (SPLIT_MISALIGNED == 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      misalign_err_q <= 1'b0;
      illegal_err_q  <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      data_q         <= data_d;
      be_q           <= be_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      misalign_err_q <= misalign_err_d;
      illegal_err_q  <= illegal_err_d;
    end
  end

  assign mem_addr     = mem_valid ? addr_q[rd_ptr_q] : '0;
  assign mem_wdata    = mem_valid ? data_q[rd_ptr_q] : '0;
  assign mem_be       = mem_valid ? be_q[rd_ptr_q]   : '0;
  assign misalign_err = misalign_err_q;
  assign illegal_err  = illegal_err_q;
  assign count        = count_q;

endmodule
